// File: rtl/perf_event_counter_if.sv
// Read port of the performance counter block: a one-cycle registered
// request/response bus used by a debug or bench reader.
interface perf_event_counter_if #(
    parameter int SEL_WIDTH = 4,
    parameter int CNT_WIDTH = 32
);
    logic                 rd_en;
    logic [SEL_WIDTH-1:0] rd_sel;
    logic [CNT_WIDTH-1:0] rd_data;
    logic                 rd_valid;

    modport master (
        output rd_en,
        output rd_sel,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  rd_en,
        input  rd_sel,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/perf_event_counter.sv
// Per-cycle event counters with a cycle counter, halt / watchdog freeze,
// sticky saturation flags and a registered read port.
module perf_event_counter #(
    parameter int NUM_EVENTS  = 6,
    parameter int CNT_WIDTH   = 32,
    parameter int SEL_WIDTH   = 4,
    parameter int CYCLE_LIMIT = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  halt,
    input  logic                  clear,
    perf_event_counter_if.slave   rd_bus,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [NUM_EVENTS-1:0] saturated,
    output logic                  running,
    output logic                  frozen,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam longint               CNT_MAX_L = (64'sd1 << CNT_WIDTH) - 64'sd1;
    // A limit the counter can never reach (it saturates first) disables the watchdog.
    localparam bit                   WDOG_EN  = (CYCLE_LIMIT > 32'sd0) &&
                                                (longint'(CYCLE_LIMIT) <= CNT_MAX_L);
    localparam logic [CNT_WIDTH-1:0] LIMIT_C  = CNT_WIDTH'(CYCLE_LIMIT);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]  cyc_q, cyc_d;
    logic [NUM_EVENTS-1:0] sat_q, sat_d;
    logic                  timeout_q, timeout_d;
    logic                  running_q, running_d;
    logic                  frozen_q, frozen_d;
    logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [CNT_WIDTH-1:0]  cyc_inc;
    logic [CNT_WIDTH-1:0]  rd_sel_val;
    logic                  wdog_hit;

    assign cyc_inc  = sat_inc(cyc_q);
    assign wdog_hit = WDOG_EN && (cyc_inc == LIMIT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear overrides everything; FROZEN is only left through clear or reset.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = enable ? ST_RUN : ST_IDLE;
                ST_RUN:    state_d = (halt || wdog_hit) ? ST_FROZEN : ST_RUN;
                ST_FROZEN: state_d = ST_FROZEN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running_d = (state_d == ST_RUN);
        frozen_d  = (state_d == ST_FROZEN);
    end

    // The halt / watchdog cycle itself is still counted; timeout only when halt is absent.
    always_comb begin
        cyc_d     = cyc_q;
        sat_d     = sat_q;
        timeout_d = timeout_q;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clear) begin
            cyc_d     = CNT_ZERO;
            sat_d     = {NUM_EVENTS{1'b0}};
            timeout_d = 1'b0;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt_d[i] = CNT_ZERO;
            end
        end else if (state_q == ST_RUN) begin
            cyc_d     = cyc_inc;
            timeout_d = timeout_q | (wdog_hit & ~halt);
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (event_in[i]) begin
                    cnt_d[i] = sat_inc(cnt_q[i]);
                    sat_d[i] = sat_q[i] | (cnt_q[i] == CNT_MAX);
                end else begin
                    cnt_d[i] = cnt_q[i];
                    sat_d[i] = sat_q[i];
                end
            end
        end else begin
            cyc_d = cyc_q;
        end
    end

    // Reads sample pre-update values, so a read never races an increment.
    always_comb begin
        rd_sel_val = CNT_ZERO;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            rd_sel_val = (rd_bus.rd_sel == SEL_WIDTH'(i)) ? cnt_q[i] : rd_sel_val;
        end
        rd_sel_val = (rd_bus.rd_sel == SEL_WIDTH'(NUM_EVENTS)) ? cyc_q : rd_sel_val;
        rd_valid_d = rd_bus.rd_en;
        if (rd_bus.rd_en) begin
            rd_data_d = rd_sel_val;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q      <= CNT_ZERO;
            sat_q      <= {NUM_EVENTS{1'b0}};
            timeout_q  <= 1'b0;
            running_q  <= 1'b0;
            frozen_q   <= 1'b0;
            rd_data_q  <= CNT_ZERO;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            cyc_q      <= cyc_d;
            sat_q      <= sat_d;
            timeout_q  <= timeout_d;
            running_q  <= running_d;
            frozen_q   <= frozen_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cycle_count     = cyc_q;
    assign saturated       = sat_q;
    assign timeout         = timeout_q;
    assign running         = running_q;
    assign frozen          = frozen_q;
    assign rd_bus.rd_data  = rd_data_q;
    assign rd_bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench: three instances (default, 8-bit counters, 20-cycle watchdog) share
// stimulus and are checked against a behavioural model of the counting rules.
module tb_perf_event_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [5:0] event_in;
    logic       halt;
    logic       clear;
    logic       rd_en;
    logic [3:0] rd_sel;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    perf_event_counter_if #(.SEL_WIDTH(4), .CNT_WIDTH(32)) bus_a ();
    perf_event_counter_if #(.SEL_WIDTH(4), .CNT_WIDTH(8))  bus_b ();
    perf_event_counter_if #(.SEL_WIDTH(4), .CNT_WIDTH(32)) bus_c ();

    assign bus_a.rd_en  = rd_en;
    assign bus_a.rd_sel = rd_sel;
    assign bus_b.rd_en  = rd_en;
    assign bus_b.rd_sel = rd_sel;
    assign bus_c.rd_en  = rd_en;
    assign bus_c.rd_sel = rd_sel;

    logic [31:0] a_cyc, c_cyc;
    logic [7:0]  b_cyc;
    logic [5:0]  a_sat, b_sat, c_sat;
    logic        a_run, b_run, c_run, a_frz, b_frz, c_frz, a_to, b_to, c_to;

    perf_event_counter #(.NUM_EVENTS(6), .CNT_WIDTH(32), .SEL_WIDTH(4), .CYCLE_LIMIT(100000)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_in(event_in), .halt(halt),
        .clear(clear), .rd_bus(bus_a), .cycle_count(a_cyc), .saturated(a_sat),
        .running(a_run), .frozen(a_frz), .timeout(a_to));

    perf_event_counter #(.NUM_EVENTS(6), .CNT_WIDTH(8), .SEL_WIDTH(4), .CYCLE_LIMIT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_in(event_in), .halt(halt),
        .clear(clear), .rd_bus(bus_b), .cycle_count(b_cyc), .saturated(b_sat),
        .running(b_run), .frozen(b_frz), .timeout(b_to));

    perf_event_counter #(.NUM_EVENTS(6), .CNT_WIDTH(32), .SEL_WIDTH(4), .CYCLE_LIMIT(20)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_in(event_in), .halt(halt),
        .clear(clear), .rd_bus(bus_c), .cycle_count(c_cyc), .saturated(c_sat),
        .running(c_run), .frozen(c_frz), .timeout(c_to));

    logic [31:0] o_cyc [3];
    logic [31:0] o_rdd [3];
    logic [5:0]  o_sat [3];
    logic        o_rv  [3];
    logic        o_run [3];
    logic        o_frz [3];
    logic        o_to  [3];

    assign o_cyc[0] = a_cyc;
    assign o_cyc[1] = {24'd0, b_cyc};
    assign o_cyc[2] = c_cyc;
    assign o_rdd[0] = bus_a.rd_data;
    assign o_rdd[1] = {24'd0, bus_b.rd_data};
    assign o_rdd[2] = bus_c.rd_data;
    assign o_sat[0] = a_sat;
    assign o_sat[1] = b_sat;
    assign o_sat[2] = c_sat;
    assign o_rv[0]  = bus_a.rd_valid;
    assign o_rv[1]  = bus_b.rd_valid;
    assign o_rv[2]  = bus_c.rd_valid;
    assign o_run[0] = a_run;
    assign o_run[1] = b_run;
    assign o_run[2] = c_run;
    assign o_frz[0] = a_frz;
    assign o_frz[1] = b_frz;
    assign o_frz[2] = c_frz;
    assign o_to[0]  = a_to;
    assign o_to[1]  = b_to;
    assign o_to[2]  = c_to;

    // Reference model: 0 = idle, 1 = run, 2 = frozen
    localparam longint M_MAX [3] = '{64'd4294967295, 64'd255, 64'd4294967295};
    localparam longint M_LIM [3] = '{64'd100000, 64'd0, 64'd20};
    longint m_cnt [3][6];
    longint m_cyc [3];
    longint m_rdd [3];
    bit [5:0] m_sat [3];
    bit      m_to [3];
    bit      m_rv [3];
    int      m_st [3];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) m_cnt[k][i] = 0;
            m_cyc[k] = 0; m_rdd[k] = 0; m_sat[k] = '0;
            m_to[k] = 0; m_rv[k] = 0; m_st[k] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 3; k++) begin
            m_rv[k] = rd_en;
            if (rd_en) begin
                if (rd_sel < 4'd6)       m_rdd[k] = m_cnt[k][rd_sel];
                else if (rd_sel == 4'd6) m_rdd[k] = m_cyc[k];
                else                     m_rdd[k] = 0;
            end
            if (clear) begin
                for (int i = 0; i < 6; i++) m_cnt[k][i] = 0;
                m_cyc[k] = 0; m_sat[k] = '0; m_to[k] = 0; m_st[k] = 0;
            end else if (m_st[k] == 0) begin
                if (enable) m_st[k] = 1;
            end else if (m_st[k] == 1) begin
                if (m_cyc[k] < M_MAX[k]) m_cyc[k] = m_cyc[k] + 1;
                for (int i = 0; i < 6; i++) begin
                    if (event_in[i]) begin
                        if (m_cnt[k][i] == M_MAX[k]) m_sat[k][i] = 1'b1;
                        else m_cnt[k][i] = m_cnt[k][i] + 1;
                    end
                end
                if (halt) m_st[k] = 2;
                else if (M_LIM[k] != 0 && m_cyc[k] == M_LIM[k]) begin
                    m_st[k] = 2;
                    m_to[k] = 1'b1;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; event_in = '0; halt = 1'b0; clear = 1'b0;
        rd_en = 1'b0; rd_sel = '0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({o_cyc[k], o_rdd[k], o_sat[k], o_rv[k], o_run[k], o_frz[k], o_to[k]} !== 75'd0) begin
                failures++;
                $display("FAIL reset dut%0d: cyc=%0h rdd=%0h sat=%b rv=%b run=%b frz=%b to=%b, all required 0",
                         k, o_cyc[k], o_rdd[k], o_sat[k], o_rv[k], o_run[k], o_frz[k], o_to[k]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_count();
        enable = 1'b1; tick(); enable = 1'b0;
        event_in = 6'b000001;
        repeat (10) tick();
        halt = 1'b1; tick(); halt = 1'b0; event_in = '0;
        checks++;
        if (o_cyc[0] !== 32'd11) begin
            failures++; $display("FAIL basic_cyc: got %0d expected 11", o_cyc[0]);
        end
        checks++;
        if ({o_frz[0], o_run[0], o_to[0]} !== 3'b100) begin
            failures++; $display("FAIL basic_flags: frz/run/to got %b%b%b expected 100", o_frz[0], o_run[0], o_to[0]);
        end
        rd_en = 1'b1; rd_sel = 4'd0; tick();
        checks++;
        if (o_rv[0] !== 1'b1 || o_rdd[0] !== 32'd11) begin
            failures++; $display("FAIL basic_rd0: rv=%b data=%0d expected rv=1 data=11", o_rv[0], o_rdd[0]);
        end
        rd_sel = 4'd1; tick(); rd_en = 1'b0;
        checks++;
        if (o_rdd[0] !== 32'd0) begin
            failures++; $display("FAIL basic_rd1: got %0d expected 0", o_rdd[0]);
        end
        tick();
        checks++;
        if (o_rv[0] !== 1'b0 || o_rdd[0] !== 32'd0) begin
            failures++; $display("FAIL basic_hold: rv=%b data=%0d expected rv=0 data=0", o_rv[0], o_rdd[0]);
        end
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_saturation();
        enable = 1'b1; tick(); enable = 1'b0;
        event_in = 6'b000100;
        repeat (300) tick();
        event_in = '0; halt = 1'b1; tick(); halt = 1'b0;
        checks++;
        if (o_cyc[1] !== 32'd255 || o_sat[1] !== 6'b000100) begin
            failures++; $display("FAIL sat_b: cyc=%0d sat=%b expected cyc=255 sat=000100", o_cyc[1], o_sat[1]);
        end
        checks++;
        if (o_cyc[0] !== 32'd301 || o_sat[0] !== 6'b000000) begin
            failures++; $display("FAIL sat_a: cyc=%0d sat=%b expected cyc=301 sat=000000", o_cyc[0], o_sat[0]);
        end
        rd_en = 1'b1; rd_sel = 4'd2; tick(); rd_en = 1'b0;
        checks++;
        if (o_rdd[1] !== 32'd255 || o_rdd[0] !== 32'd300) begin
            failures++; $display("FAIL sat_rd: b=%0d a=%0d expected b=255 a=300", o_rdd[1], o_rdd[0]);
        end
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_watchdog();
        enable = 1'b1; tick(); enable = 1'b0;
        repeat (25) begin event_in = 6'($urandom); tick(); end
        checks++;
        if (o_cyc[2] !== 32'd20 || o_to[2] !== 1'b1 || o_frz[2] !== 1'b1) begin
            failures++; $display("FAIL wdog_c: cyc=%0d to=%b frz=%b expected 20 1 1", o_cyc[2], o_to[2], o_frz[2]);
        end
        checks++;
        if (o_run[0] !== 1'b1 || o_cyc[0] !== 32'd25) begin
            failures++; $display("FAIL wdog_a: run=%b cyc=%0d expected run=1 cyc=25", o_run[0], o_cyc[0]);
        end
        repeat (5) begin event_in = 6'($urandom); tick(); end
        event_in = '0;
        checks++;
        if (o_cyc[2] !== 32'd20 || o_cyc[2] !== 32'(m_cyc[2])) begin
            failures++; $display("FAIL wdog_hold: cyc=%0d expected 20", o_cyc[2]);
        end
    endtask

    task automatic test_read_sweep();
        halt = 1'b1; tick(); halt = 1'b0;
        for (int s = 0; s < 8; s++) begin
            rd_en = 1'b1; rd_sel = 4'(s); tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (o_rv[k] !== 1'b1 || o_rdd[k] !== 32'(m_rdd[k])) begin
                    failures++; $display("FAIL sweep dut%0d sel%0d: rv=%b data=%0d expected rv=1 data=%0d",
                                         k, s, o_rv[k], o_rdd[k], m_rdd[k]);
                end
            end
            checks++;
            if ((s == 6 && o_rdd[2] !== 32'd20) || (s == 7 && o_rdd[0] !== 32'd0)) begin
                failures++; $display("FAIL sweep_const sel%0d: c=%0d a=%0d", s, o_rdd[2], o_rdd[0]);
            end
        end
        rd_en = 1'b0; tick();
        checks++;
        if (o_rv[0] !== 1'b0) begin
            failures++; $display("FAIL sweep_rv_off: got %b expected 0", o_rv[0]);
        end
    endtask

    task automatic test_clear_priority();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                enable = 1'b1; tick(); enable = 1'b0;
                event_in = 6'b101010; repeat (4) tick();
            end
            clear = 1'b1; halt = 1'b1; enable = 1'b1; event_in = 6'h3f; tick();
            clear = 1'b0; halt = 1'b0; enable = 1'b0; event_in = '0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({o_cyc[k], o_sat[k], o_to[k], o_run[k], o_frz[k]} !== 41'd0) begin
                    failures++; $display("FAIL clear pass%0d dut%0d: cyc=%0d sat=%b to=%b run=%b frz=%b expected all 0",
                                         pass, k, o_cyc[k], o_sat[k], o_to[k], o_run[k], o_frz[k]);
                end
            end
        end
        enable = 1'b1; tick(); enable = 1'b0;
        event_in = 6'b000011; repeat (3) tick(); event_in = '0;
        rd_en = 1'b1; rd_sel = 4'd1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_cyc[k] !== 32'd3) begin
                failures++; $display("FAIL restart_cyc dut%0d: got %0d expected 3", k, o_cyc[k]);
            end
        end
        tick(); rd_en = 1'b0;
        checks++;
        if (o_rdd[1] !== 32'd3) begin
            failures++; $display("FAIL restart_rd: got %0d expected 3", o_rdd[1]);
        end
    endtask

    task automatic test_back_to_back();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int n = 0; n < 600; n++) begin
            enable   = ($urandom_range(0, 3) != 0);
            halt     = ($urandom_range(0, 299) == 0);
            clear    = ($urandom_range(0, 149) == 0);
            event_in = 6'($urandom);
            rd_en    = $urandom_range(0, 1);
            rd_sel   = 4'($urandom_range(0, 15));
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (o_cyc[k] !== 32'(m_cyc[k]) || o_sat[k] !== m_sat[k] || o_to[k] !== m_to[k] ||
                    o_run[k] !== (m_st[k] == 1) || o_frz[k] !== (m_st[k] == 2) ||
                    o_rv[k] !== m_rv[k] || o_rdd[k] !== 32'(m_rdd[k])) begin
                    failures++;
                    $display("FAIL random n%0d dut%0d: cyc=%0d/%0d sat=%b/%b to=%b/%b run=%b frz=%b st=%0d rv=%b/%b rdd=%0d/%0d",
                             n, k, o_cyc[k], m_cyc[k], o_sat[k], m_sat[k], o_to[k], m_to[k],
                             o_run[k], o_frz[k], m_st[k], o_rv[k], m_rv[k], o_rdd[k], m_rdd[k]);
                end
            end
        end
        enable = 1'b0; halt = 1'b0; clear = 1'b0; event_in = '0; rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        clear = 1'b1; tick(); clear = 1'b0;
        enable = 1'b1; tick(); enable = 1'b0;
        event_in = 6'b111111; repeat (5) tick();
        rd_en = 1'b1; rd_sel = 4'd6; tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({o_cyc[k], o_rdd[k], o_sat[k], o_rv[k], o_run[k], o_frz[k], o_to[k]} !== 75'd0) begin
                failures++;
                $display("FAIL midreset dut%0d: cyc=%0h rdd=%0h sat=%b rv=%b run=%b frz=%b to=%b, all required 0",
                         k, o_cyc[k], o_rdd[k], o_sat[k], o_rv[k], o_run[k], o_frz[k], o_to[k]);
            end
        end
        @(negedge clk);
        rd_en = 1'b0; event_in = '0;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_rv[k] !== 1'b0 || o_run[k] !== 1'b0 || o_frz[k] !== 1'b0 || o_cyc[k] !== 32'd0) begin
                failures++; $display("FAIL postreset dut%0d: rv=%b run=%b frz=%b cyc=%0d expected 0 0 0 0",
                                     k, o_rv[k], o_run[k], o_frz[k], o_cyc[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_saturation();
        test_watchdog();
        test_read_sweep();
        test_clear_priority();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
